// File: rtl/alu_arbiter.sv
// alu_arbiter
// Two-requester front end for one shared combinational ALU. A single
// response register holds the ALU result of the accepted operation
// until the consumer takes it. When the consumer takes the held
// response, a new operation can be accepted on the same edge, so one
// operation per cycle is sustained.
//
// Optional feature macro: ALU_ARB_ROUND_ROBIN_EN
//   defined   : on contention the port that did not win last time is granted
//   undefined : port 0 always wins contention; no grant history is kept
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 6
) (
    input  logic              Clk,
    input  logic              Reset,

    input  logic              Req0Valid,
    output logic              Req0Ready,
    input  logic [CTRL_W-1:0] Req0Ctrl,
    input  logic [DATA_W-1:0] Req0A,
    input  logic [DATA_W-1:0] Req0B,

    input  logic              Req1Valid,
    output logic              Req1Ready,
    input  logic [CTRL_W-1:0] Req1Ctrl,
    input  logic [DATA_W-1:0] Req1A,
    input  logic [DATA_W-1:0] Req1B,

    output logic [CTRL_W-1:0] AluControl,
    output logic [DATA_W-1:0] AluA,
    output logic [DATA_W-1:0] AluB,
    input  logic [DATA_W-1:0] AluResult,
    input  logic              AluZero,

    output logic              RespValid,
    input  logic              RespReady,
    output logic              RespId,
    output logic [DATA_W-1:0] RespResult,
    output logic              RespZero
);

    // state | meaning
    // EMPTY | no response held; RespReady has no effect
    // FULL  | response held; it stays frozen until RespReady=1
    localparam logic STATE_EMPTY = 1'b0;
    localparam logic STATE_FULL  = 1'b1;

    logic              state_q, state_d;
    logic              resp_id_q, resp_id_d;
    logic [DATA_W-1:0] resp_result_q, resp_result_d;
    logic              resp_zero_q, resp_zero_d;

    logic              slot_free;
    logic              grant_valid;
    logic              grant_id;
    logic              accept;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic              last_grant_q, last_grant_d;
`endif

    // Pick the port that would be served this cycle, from the valids alone.
    always_comb begin
        grant_valid = Req0Valid | Req1Valid;
        grant_id    = 1'b0;
        if (Req0Valid && Req1Valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            grant_id = ~last_grant_q;
`else
            grant_id = 1'b0;
`endif
        end else if (Req1Valid) begin
            grant_id = 1'b1;
        end
    end

    // Handshake: the slot frees up when empty or when the held response leaves
    // this cycle; reset blocks every accept.
    always_comb begin
        slot_free = (state_q == STATE_EMPTY) || RespReady;
        Req0Ready = !Reset && slot_free && grant_valid && (grant_id == 1'b0);
        Req1Ready = !Reset && slot_free && grant_valid && (grant_id == 1'b1);
        accept    = Req0Ready || Req1Ready;
    end

    // Steer the granted operation to the shared ALU; drive zeros when idle so
    // the ALU inputs do not toggle with stale requester data.
    always_comb begin
        AluControl = '0;
        AluA       = '0;
        AluB       = '0;
        if (grant_valid) begin
            if (grant_id) begin
                AluControl = Req1Ctrl;
                AluA       = Req1A;
                AluB       = Req1B;
            end else begin
                AluControl = Req0Ctrl;
                AluA       = Req0A;
                AluB       = Req0B;
            end
        end
    end

    // Next state of the response slot; an accept always wins over a drain so
    // back-to-back operations keep the slot FULL.
    always_comb begin
        state_d       = state_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_zero_d   = resp_zero_q;
        if (accept) begin
            state_d       = STATE_FULL;
            resp_id_d     = grant_id;
            resp_result_d = AluResult;
            resp_zero_d   = AluZero;
        end else if ((state_q == STATE_FULL) && RespReady) begin
            state_d = STATE_EMPTY;
        end
    end

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Grant history moves only when an operation is actually taken.
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant_id;
        end
    end

    // Grant history register; reset value makes port 0 win the first contention.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Response slot registers; reset discards any held response.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= STATE_EMPTY;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_zero_q   <= resp_zero_d;
        end
    end

    // Registered response outputs.
    always_comb begin
        RespValid  = (state_q == STATE_FULL);
        RespId     = resp_id_q;
        RespResult = resp_result_q;
        RespZero   = resp_zero_q;
    end

endmodule
